// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table checker.
package truth_table_checker_pkg;

  localparam int N_VEC = 16;
  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_checker_vec_sequencer.sv
// Vector sequencer: holds each input vector for SETTLE cycles and flags the
// cycle in which the DUT response should be sampled.
module truth_table_checker_vec_sequencer
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  output logic [VEC_W-1:0] abcd,
  output logic             sample_en,
  output logic             last_vec
);

  // A one-cycle settle window still needs a 1-bit counter to keep widths legal.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(N_VEC - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0] abcd_q, abcd_d;

  assign abcd      = abcd_q;
  assign last_vec  = (abcd_q == VEC_LAST);
  assign sample_en = run && (cnt_q == CNT_LAST);

  // Next-state: restart on clear, otherwise advance while running; the
  // vector counter parks on the last vector after the sweep.
  always_comb begin
    cnt_d  = cnt_q;
    abcd_d = abcd_q;
    if (clear) begin
      cnt_d  = '0;
      abcd_d = '0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (!last_vec) abcd_d = abcd_q + VEC_W'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      abcd_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      abcd_q <= abcd_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps all 16 input vectors of a 4-input function,
// captures its response and compares it against the expected mask.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXP_MASK = 16'hA5C3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f,
  output logic [VEC_W-1:0] abcd,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      captured,
  output logic [4:0]       fail_count,
  output logic [3:0]       first_fail_idx
);

  state_e      state_q, state_d;
  logic [15:0] captured_q, captured_d;
  logic [4:0]  fail_count_q, fail_count_d;
  logic [3:0]  first_fail_idx_q, first_fail_idx_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic start_acc;
  logic sample_en;
  logic last_vec;

  assign start_acc = (state_q == ST_IDLE) && start;

  truth_table_checker_vec_sequencer #(.SETTLE(SETTLE)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .run      (state_q == ST_APPLY),
    .abcd     (abcd),
    .sample_en(sample_en),
    .last_vec (last_vec)
  );

  // FSM and result bookkeeping; pass is computed from the updated failure
  // count at the final sample so it is already valid in the done cycle.
  always_comb begin
    state_d          = state_q;
    captured_d       = captured_q;
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    pass_d           = pass_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_APPLY;
          captured_d       = '0;
          fail_count_d     = '0;
          first_fail_idx_d = '0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
        end
      end
      ST_APPLY: begin
        if (sample_en) begin
          captured_d[abcd] = f;
          if (f != EXP_MASK[abcd]) begin
            fail_count_d = fail_count_q + 5'd1;
            if (fail_count_q == 5'd0) first_fail_idx_d = abcd;
          end
          if (last_vec) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_count_d == 5'd0);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      captured_q       <= '0;
      fail_count_q     <= '0;
      first_fail_idx_q <= '0;
      pass_q           <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      captured_q       <= captured_d;
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      pass_q           <= pass_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign captured       = captured_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;

endmodule
